// File: rtl/point_stream_reader_pkg.sv
// Shared definitions for the point stream reader.
// Holds the packed point record layout (field positions and widths inside one
// ZBT word) and the state encoding of the frame sweep controller.
package point_stream_reader_pkg;

    // Packed point record layout within a ZBT data word
    localparam int REC_X_LSB     = 0;
    localparam int REC_X_WIDTH   = 10;
    localparam int REC_Y_LSB     = 10;
    localparam int REC_Y_WIDTH   = 10;
    localparam int REC_VALID_BIT = 35;

    // Frame sweep controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/point_stream_reader_if.sv
// Bus bundle of the point stream reader.
// Groups the ZBT read port and the downstream point handshake.
//   zbt_read_addr  registered ZBT read address (reader -> ZBT)
//   zbt_read_data  ZBT read data               (ZBT -> reader)
//   point_x/y      FIFO head coordinates       (reader -> rasteriser)
//   point_valid    FIFO head is valid          (reader -> rasteriser)
//   point_ready    rasteriser accepts the head (rasteriser -> reader)
// master: the reader side; slave: the ZBT/rasteriser side.
interface point_stream_reader_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 36,
    parameter int X_WIDTH    = 10,
    parameter int Y_WIDTH    = 10
);
    logic [ADDR_WIDTH-1:0] zbt_read_addr;
    logic [DATA_WIDTH-1:0] zbt_read_data;
    logic [X_WIDTH-1:0]    point_x;
    logic [Y_WIDTH-1:0]    point_y;
    logic                  point_valid;
    logic                  point_ready;

    modport master (
        output zbt_read_addr,
        output point_x,
        output point_y,
        output point_valid,
        input  zbt_read_data,
        input  point_ready
    );

    modport slave (
        input  zbt_read_addr,
        input  point_x,
        input  point_y,
        input  point_valid,
        output zbt_read_data,
        output point_ready
    );
endinterface

// File: rtl/point_fifo.sv
// First-word-fall-through FIFO with occupancy count.
//   clk, reset  clock and asynchronous active-high reset
//   push        write push_data this cycle (ignored when full without pop)
//   push_data   entry to write
//   pop         remove the head this cycle (ignored when empty)
//   pop_data    current head; reads as zero while empty
//   empty       no entries held
//   count       number of entries held (0..DEPTH)
module point_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO is kept.
    assign do_push = push && (!full || do_pop);

    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/point_stream_reader.sv
// Per-frame ZBT point record sweeper.
// At frame start (hcount==0, vcount==0) it latches a base address and record
// count, then reads one record per hcount phase slot, unpacks x/y from the
// records flagged present and hands them to the rasteriser through a FWFT FIFO.
//   clk, reset     clock and asynchronous active-high reset
//   hcount/vcount  raster position, used for frame start and the read slot
//   base_addr      first record address, sampled at frame start
//   point_count    records to scan, sampled at frame start (0 = none)
//   bus            ZBT read port and point valid/ready stream (master side)
//   busy           a scan or drain is in progress
//   frame_done     one-cycle pulse once the frame's last point has left
//   overrun        one-cycle pulse when a frame start arrives while busy
module point_stream_reader
    import point_stream_reader_pkg::*;
#(
    parameter int ADDR_WIDTH   = 19,
    parameter int DATA_WIDTH   = 36,
    parameter int X_WIDTH      = REC_X_WIDTH,
    parameter int Y_WIDTH      = REC_Y_WIDTH,
    parameter int X_LSB        = REC_X_LSB,
    parameter int Y_LSB        = REC_Y_LSB,
    parameter int VALID_BIT    = REC_VALID_BIT,
    parameter int READ_LATENCY = 2,
    parameter int READ_PHASE   = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [10:0]           hcount,
    input  logic [9:0]            vcount,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] point_count,
    point_stream_reader_if.master bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = X_WIDTH + Y_WIDTH;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] remaining;
    logic [READ_LATENCY:0] tag;
    int                    inflight;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic [PW-1:0]         push_data;
    logic [PW-1:0]         head;
    logic                  frame_start;
    logic                  slot;
    logic                  credit_ok;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  unused_data_bits;

    assign frame_start = (hcount == 11'd0) && (vcount == 10'd0);
    assign slot        = (hcount[1:0] == 2'(READ_PHASE));

    // Every issued read reserves a FIFO slot until its record has been
    // captured, whether or not the record turns out to be present.
    assign inflight  = $countones(tag);
    assign credit_ok = (int'(fifo_count) + inflight) < FIFO_DEPTH;
    assign issue     = (state == SCAN) && slot && (remaining != '0) && credit_ok;

    // Issue -> capture: one cycle to register the address, then READ_LATENCY
    // cycles of ZBT latency; the tag leaving the last stage marks valid data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag <= '0;
        end else begin
            tag <= {tag[READ_LATENCY-1:0], issue};
        end
    end

    assign push      = tag[READ_LATENCY] && bus.zbt_read_data[VALID_BIT];
    assign push_data = {bus.zbt_read_data[Y_LSB +: Y_WIDTH],
                        bus.zbt_read_data[X_LSB +: X_WIDTH]};
    assign unused_data_bits = ^bus.zbt_read_data;

    assign pop             = bus.point_valid && bus.point_ready;
    assign bus.point_valid = !fifo_empty;
    assign bus.point_x     = head[X_WIDTH-1:0];
    assign bus.point_y     = head[PW-1:X_WIDTH];

    point_fifo #(
        .WIDTH (PW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            cur_addr          <= '0;
            remaining         <= '0;
            bus.zbt_read_addr <= '0;
            frame_done        <= 1'b0;
            overrun           <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // A frame start during a frame is only reported, never restarts.
            overrun    <= frame_start && (state != IDLE);
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        cur_addr  <= base_addr;
                        remaining <= point_count;
                        state     <= (point_count == '0) ? DRAIN : SCAN;
                    end
                end
                SCAN: begin
                    if (issue) begin
                        bus.zbt_read_addr <= cur_addr;
                        cur_addr          <= cur_addr + ADDR_WIDTH'(1);
                        remaining         <= remaining - ADDR_WIDTH'(1);
                        if (remaining == ADDR_WIDTH'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if ((inflight == 0) && fifo_empty) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_point_stream_reader.sv
// Directed bench for point_stream_reader: three instances (READ_LATENCY 2, 1
// and 4) share raster/control inputs; each has its own ZBT model.
module tb_point_stream_reader;
    localparam int AW = 19;
    localparam int DW = 36;

    logic          clk = 1'b0;
    logic          reset;
    logic [10:0]   hcount;
    logic [9:0]    vcount;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] point_count;
    logic          busy_a, fdone_a, ovr_a;
    logic          unused_busy_b, fdone_b, unused_ovr_b;
    logic          unused_busy_c, fdone_c, unused_ovr_c;

    point_stream_reader_if ifa ();
    point_stream_reader_if ifb ();
    point_stream_reader_if ifc ();

    point_stream_reader #(.READ_LATENCY(2)) dut_a (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .base_addr(base_addr), .point_count(point_count), .bus(ifa),
        .busy(busy_a), .frame_done(fdone_a), .overrun(ovr_a));
    point_stream_reader #(.READ_LATENCY(1)) dut_b (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .base_addr(base_addr), .point_count(point_count), .bus(ifb),
        .busy(unused_busy_b), .frame_done(fdone_b), .overrun(unused_ovr_b));
    point_stream_reader #(.READ_LATENCY(4)) dut_c (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .base_addr(base_addr), .point_count(point_count), .bus(ifc),
        .busy(unused_busy_c), .frame_done(fdone_c), .overrun(unused_ovr_c));

    always #5 clk = ~clk;

    int            n_assert = 0;
    int            n_fail   = 0;
    int            tcount;
    logic [31:0]   hole_mask;
    logic [AW-1:0] hist_a [3];
    logic [AW-1:0] hist_b [2];
    logic [AW-1:0] hist_c [5];
    logic [AW-1:0] last_addr;
    logic [AW-1:0] addr_log [$];
    int            addr_t [$];
    logic [9:0]    xa [$], ya [$], xb [$], yb [$], xc [$], yc [$];
    int            fd_a, fd_b, fd_c, ov_a;
    logic          saw_valid;
    int            hole_exp [$] = '{'h200, 'h202, 'h203, 'h205};
    int            wrap_exp [$] = '{'h7FFFE, 'h7FFFF, 'h00000, 'h00001};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ZBT record: x = addr[9:0], y = ~addr[9:0], filler in the spare bits,
    // present unless the address's low 5 bits select a hole.
    function automatic logic [DW-1:0] rec(input logic [AW-1:0] a);
        logic [DW-1:0] r;
        r        = '0;
        r[9:0]   = a[9:0];
        r[19:10] = ~a[9:0];
        r[34:20] = 15'h2A5A;
        r[35]    = !hole_mask[a[4:0]];
        return r;
    endfunction

    task automatic tick();
        logic       pa, pb, pc;
        logic [9:0] ax, ay, bx, by, cx, cy;
        pa = ifa.point_valid && ifa.point_ready; ax = ifa.point_x; ay = ifa.point_y;
        pb = ifb.point_valid && ifb.point_ready; bx = ifb.point_x; by = ifb.point_y;
        pc = ifc.point_valid && ifc.point_ready; cx = ifc.point_x; cy = ifc.point_y;
        @(posedge clk);
        #1;
        tcount++;
        if (pa) begin xa.push_back(ax); ya.push_back(ay); end
        if (pb) begin xb.push_back(bx); yb.push_back(by); end
        if (pc) begin xc.push_back(cx); yc.push_back(cy); end
        if (ifa.point_valid) saw_valid = 1'b1;
        if (fdone_a) fd_a++;
        if (fdone_b) fd_b++;
        if (fdone_c) fd_c++;
        if (ovr_a)   ov_a++;
        if (ifa.zbt_read_addr !== last_addr) begin
            addr_log.push_back(ifa.zbt_read_addr);
            addr_t.push_back(tcount);
            last_addr = ifa.zbt_read_addr;
        end
        hist_a[2] = hist_a[1]; hist_a[1] = hist_a[0]; hist_a[0] = ifa.zbt_read_addr;
        ifa.zbt_read_data = rec(hist_a[2]);
        hist_b[1] = hist_b[0]; hist_b[0] = ifb.zbt_read_addr;
        ifb.zbt_read_data = rec(hist_b[1]);
        hist_c[4] = hist_c[3]; hist_c[3] = hist_c[2]; hist_c[2] = hist_c[1];
        hist_c[1] = hist_c[0]; hist_c[0] = ifc.zbt_read_addr;
        ifc.zbt_read_data = rec(hist_c[4]);
        hcount = hcount + 11'd1;
    endtask

    task automatic clear_logs();
        addr_log.delete(); addr_t.delete();
        xa.delete(); ya.delete(); xb.delete(); yb.delete(); xc.delete(); yc.delete();
        fd_a = 0; fd_b = 0; fd_c = 0; ov_a = 0; saw_valid = 1'b0;
    endtask

    task automatic frame_start();
        hcount = 11'd0;
        vcount = 10'd0;
        tick();
        vcount = 10'd1;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (fd_a > 0 && fd_b > 0 && fd_c > 0) break;
            tick();
        end
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1; hcount = 11'd0; vcount = 10'd1;
        base_addr = '0; point_count = '0; hole_mask = '0;
        ifa.point_ready = 1'b1; ifb.point_ready = 1'b1; ifc.point_ready = 1'b1;
        ifa.zbt_read_data = '0; ifb.zbt_read_data = '0; ifc.zbt_read_data = '0;
        hist_a = '{default: '0}; hist_b = '{default: '0}; hist_c = '{default: '0};
        last_addr = '0; tcount = 0;
        clear_logs();
        repeat (3) tick();

        // Reset state
        check("rst_busy",  32'(busy_a), 0);
        check("rst_valid", 32'(ifa.point_valid), 0);
        check("rst_done",  32'(fdone_a), 0);
        check("rst_ovr",   32'(ovr_a), 0);
        check("rst_addr",  32'(ifa.zbt_read_addr), 0);
        check("rst_x",     32'(ifa.point_x), 0);
        check("rst_y",     32'(ifa.point_y), 0);
        reset = 1'b0;
        repeat (2) tick();

        // Basic scan, all three latencies
        base_addr = 19'h00100; point_count = 19'd4;
        clear_logs();
        frame_start();
        wait_done(200);
        check("basic_nreads", addr_log.size(), 4);
        for (int i = 0; i < 4; i++) check("basic_addr", 32'(addr_log[i]), 'h100 + i);
        for (int i = 1; i < 4; i++) check("basic_spacing", addr_t[i] - addr_t[i-1], 4);
        check("basic_npts_l2", xa.size(), 4);
        check("basic_npts_l1", xb.size(), 4);
        check("basic_npts_l4", xc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("basic_x_l2", 32'(xa[i]), 'h100 + i);
            check("basic_y_l2", 32'(ya[i]), 'h2FF - i);
            check("basic_x_l1", 32'(xb[i]), 'h100 + i);
            check("basic_y_l1", 32'(yb[i]), 'h2FF - i);
            check("basic_x_l4", 32'(xc[i]), 'h100 + i);
            check("basic_y_l4", 32'(yc[i]), 'h2FF - i);
        end
        check("basic_done_l2", fd_a, 1);
        check("basic_done_l1", fd_b, 1);
        check("basic_done_l4", fd_c, 1);
        check("basic_idle", 32'(busy_a), 0);

        // Empty slots: records at 0x201 and 0x204 absent
        base_addr = 19'h00200; point_count = 19'd6; hole_mask = 32'h12;
        clear_logs();
        frame_start();
        wait_done(200);
        check("hole_nreads", addr_log.size(), 6);
        check("hole_npts", xa.size(), 4);
        for (int i = 0; i < 4; i++) check("hole_x", 32'(xa[i]), hole_exp[i]);
        check("hole_done", fd_a, 1);
        hole_mask = '0;

        // Zero count
        base_addr = 19'h00300; point_count = 19'd0;
        clear_logs();
        frame_start();
        wait_done(50);
        check("zero_nreads", addr_log.size(), 0);
        check("zero_valid", 32'(saw_valid), 0);
        check("zero_done", fd_a, 1);

        // Address wrap
        base_addr = 19'h7FFFE; point_count = 19'd4;
        clear_logs();
        frame_start();
        wait_done(200);
        check("wrap_nreads", addr_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("wrap_addr", 32'(addr_log[i]), wrap_exp[i]);
            check("wrap_x", 32'(xa[i]), wrap_exp[i] & 'h3FF);
        end
        check("wrap_done", fd_a, 1);

        // Backpressure with a second frame start while stalled
        base_addr = 19'h00400; point_count = 19'd20; ifa.point_ready = 1'b0;
        clear_logs();
        frame_start();
        repeat (150) tick();
        check("bp_nreads", addr_log.size(), 8);
        check("bp_addr", 32'(ifa.zbt_read_addr), 'h407);
        check("bp_busy", 32'(busy_a), 1);
        check("bp_valid", 32'(ifa.point_valid), 1);
        check("bp_head_x", 32'(ifa.point_x), 'h000);
        repeat (20) tick();
        check("bp_nreads_hold", addr_log.size(), 8);
        check("bp_addr_hold", 32'(ifa.zbt_read_addr), 'h407);
        check("bp_no_ovr_yet", ov_a, 0);
        base_addr = 19'h00600;
        frame_start();
        repeat (2) tick();
        check("ovr_pulse", ov_a, 1);
        check("ovr_still_busy", 32'(busy_a), 1);
        ifa.point_ready = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (fd_a > 0) break;
            tick();
        end
        repeat (3) tick();
        check("bp_npts", xa.size(), 20);
        for (int i = 0; i < 20; i++) check("bp_x", 32'(xa[i]), i);
        check("bp_y0", 32'(ya[0]), 'h3FF);
        check("bp_nreads_all", addr_log.size(), 20);
        check("bp_last_addr", 32'(addr_log[19]), 'h413);
        check("bp_done", fd_a, 1);
        check("bp_ovr_once", ov_a, 1);

        // Reset mid-scan
        base_addr = 19'h00500; point_count = 19'd10; ifa.point_ready = 1'b0;
        clear_logs();
        frame_start();
        repeat (12) tick();
        check("mid_pre_busy", 32'(busy_a), 1);
        check("mid_pre_valid", 32'(ifa.point_valid), 1);
        reset = 1'b1;
        #1;
        check("mid_valid", 32'(ifa.point_valid), 0);
        check("mid_busy", 32'(busy_a), 0);
        check("mid_addr", 32'(ifa.zbt_read_addr), 0);
        repeat (3) tick();
        reset = 1'b0;
        ifa.point_ready = 1'b1;
        repeat (40) tick();
        check("mid_no_done", fd_a, 0);
        check("mid_idle", 32'(busy_a), 0);
        check("mid_empty", 32'(ifa.point_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
